// File: rtl/slot_pkg.sv
// Shared constants, state/outcome encodings and helpers for the slot-machine reel bank.
package slot_pkg;

    localparam int SYM_W          = 3;
    localparam int SYM_COUNT      = 6;
    localparam int NUM_REELS      = 4;
    localparam int WATCHDOG_TICKS = 255;
    localparam logic [7:0] LFSR_SEED = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SPIN = 2'd1,
        ST_EVAL = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE    = 2'd0,
        WIN_PAIR    = 2'd1,
        WIN_TRIPLE  = 2'd2,
        WIN_JACKPOT = 2'd3
    } win_class_t;

    // Folds a raw 3-bit value into the legal symbol range 0..5.
    function automatic logic [SYM_W-1:0] mod_sym(input logic [SYM_W-1:0] v);
        if (v >= SYM_W'(SYM_COUNT))
            return v - SYM_W'(SYM_COUNT);
        else
            return v;
    endfunction

    // Largest group of identical symbols across all reels decides the class.
    function automatic win_class_t classify(input logic [NUM_REELS*SYM_W-1:0] syms);
        logic [2:0] best;
        logic [2:0] cnt;
        win_class_t cls;
        best = 3'd1;
        for (int i = 0; i < NUM_REELS; i++) begin
            cnt = 3'd0;
            for (int j = 0; j < NUM_REELS; j++) begin
                if (syms[i*SYM_W +: SYM_W] == syms[j*SYM_W +: SYM_W])
                    cnt = cnt + 3'd1;
            end
            if (cnt > best)
                best = cnt;
        end
        case (best)
            3'd4:    cls = WIN_JACKPOT;
            3'd3:    cls = WIN_TRIPLE;
            3'd2:    cls = WIN_PAIR;
            default: cls = WIN_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/reel_counter.sv
// One reel position: loads a start symbol, advances on request and wraps 5 -> 0.
module reel_counter
    import slot_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [SYM_W-1:0] load_val,
    input  logic             advance,
    output logic [SYM_W-1:0] sym
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sym <= '0;
        else if (load)
            sym <= load_val;
        else if (advance)
            sym <= (sym == SYM_W'(SYM_COUNT - 1)) ? '0 : sym + SYM_W'(1);
    end

endmodule

// File: rtl/reel_bank.sv
// Four-reel slot bank: spin control FSM, stop synchronizers, watchdog and outcome evaluation.
module reel_bank
    import slot_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       spin_tick,
    input  logic [NUM_REELS-1:0]       stop_in,
    output logic                       is_spinning,
    output logic [NUM_REELS*SYM_W-1:0] reel_sym,
    output logic                       result_valid,
    output logic [1:0]                 win_class,
    output logic                       timeout
);

    state_t               state;
    logic [7:0]           lfsr;
    logic [8:0]           lfsr_ext;
    logic [NUM_REELS-1:0] sync1;
    logic [NUM_REELS-1:0] sync2;
    logic [NUM_REELS-1:0] stopped;
    logic [7:0]           watchdog;
    logic                 load;
    logic                 force_stop;
    logic                 tick_live;
    logic [NUM_REELS-1:0] advance;

    // Reel 3 wants lfsr[8:6]; bit 8 does not exist, so it reads as zero.
    assign lfsr_ext   = {1'b0, lfsr};
    assign load       = (state == ST_IDLE) && start;
    assign force_stop = (state == ST_SPIN) && spin_tick && (stopped != '1)
                        && (watchdog == 8'(WATCHDOG_TICKS - 1));
    assign tick_live  = (state == ST_SPIN) && spin_tick && !force_stop;
    assign advance    = {NUM_REELS{tick_live}} & ~stopped & ~sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr <= LFSR_SEED;
        else
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= stop_in;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < NUM_REELS; i++) begin : g_reel
        logic [SYM_W-1:0] load_val;
        assign load_val = mod_sym(lfsr_ext[2*i +: SYM_W]);

        reel_counter u_reel (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load),
            .load_val (load_val),
            .advance  (advance[i]),
            .sym      (reel_sym[i*SYM_W +: SYM_W])
        );
    end

    // Stop requests are only honoured in SPIN; a stop seen together with a tick wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            stopped      <= '0;
            watchdog     <= '0;
            is_spinning  <= 1'b0;
            result_valid <= 1'b0;
            win_class    <= WIN_NONE;
            timeout      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    result_valid <= 1'b0;
                    if (start) begin
                        state       <= ST_SPIN;
                        stopped     <= '0;
                        watchdog    <= '0;
                        timeout     <= 1'b0;
                        win_class   <= WIN_NONE;
                        is_spinning <= 1'b1;
                    end
                end
                ST_SPIN: begin
                    if (stopped == '1) begin
                        state        <= ST_EVAL;
                        is_spinning  <= 1'b0;
                        result_valid <= 1'b1;
                        win_class    <= classify(reel_sym);
                    end else begin
                        stopped <= stopped | sync2;
                        if (spin_tick)
                            watchdog <= watchdog + 8'd1;
                        if (force_stop) begin
                            stopped <= '1;
                            timeout <= 1'b1;
                        end
                    end
                end
                ST_EVAL: begin
                    result_valid <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: begin
                    state        <= ST_IDLE;
                    is_spinning  <= 1'b0;
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reel_bank.sv
// Directed bench for reel_bank: reset, wrap/priority, staggered stops, watchdog, jackpot and classes.
module tb_reel_bank;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        spin_tick = 1'b0;
    logic [3:0]  stop_in = 4'b0000;
    logic        is_spinning;
    logic [11:0] reel_sym;
    logic        result_valid;
    logic [1:0]  win_class;
    logic        timeout;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] m_lfsr;
    int         exp_sym [4];
    bit         m_stopped [4];

    reel_bank dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .spin_tick    (spin_tick),
        .stop_in      (stop_in),
        .is_spinning  (is_spinning),
        .reel_sym     (reel_sym),
        .result_valid (result_valid),
        .win_class    (win_class),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    // Free-running reference LFSR, taps 8,6,5,4, seed A5.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            m_lfsr <= 8'hA5;
        else
            m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected finish before 2000000");
        $fatal(1, "[TB] hung");
    end

    function automatic logic [11:0] pack_syms();
        logic [11:0] p;
        p = '0;
        for (int i = 0; i < 4; i++)
            p[3*i +: 3] = 3'(exp_sym[i]);
        return p;
    endfunction

    function automatic int expected_class();
        int cnt [6];
        int m;
        m = 0;
        for (int k = 0; k < 6; k++) cnt[k] = 0;
        for (int i = 0; i < 4; i++) cnt[exp_sym[i]]++;
        for (int k = 0; k < 6; k++) if (cnt[k] > m) m = cnt[k];
        return m - 1;
    endfunction

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_spin();
        logic [8:0] ext;
        ext = {1'b0, m_lfsr};
        for (int i = 0; i < 4; i++) begin
            exp_sym[i]   = int'(ext[2*i +: 3]) % 6;
            m_stopped[i] = 1'b0;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic tick();
        spin_tick = 1'b1;
        @(negedge clk);
        spin_tick = 1'b0;
        for (int i = 0; i < 4; i++)
            if (!m_stopped[i]) exp_sym[i] = (exp_sym[i] + 1) % 6;
    endtask

    task automatic wait_result(output bit found, output logic [11:0] sym,
                               output logic [1:0] wc, output logic to, output int width);
        found = 1'b0;
        width = 0;
        sym = '0;
        wc = '0;
        to = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (result_valid === 1'b1) begin
                found = 1'b1;
                sym = reel_sym;
                wc = win_class;
                to = timeout;
            end
        end
        if (found) begin
            width = 1;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (result_valid === 1'b1) width++;
                else break;
            end
        end
    endtask

    // Ticks until each reel shows its target, freezing it there with no tick during the stop latency.
    task automatic spin_to(input int t0, input int t1, input int t2, input int t3);
        int tgt [4];
        int left;
        bit hit;
        tgt[0] = t0; tgt[1] = t1; tgt[2] = t2; tgt[3] = t3;
        left = 4;
        for (int it = 0; it < 40 && left > 0; it++) begin
            hit = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (!m_stopped[i] && exp_sym[i] == tgt[i]) begin
                    stop_in[i]   = 1'b1;
                    m_stopped[i] = 1'b1;
                    left--;
                    hit = 1'b1;
                end
            end
            if (hit) begin
                if (left > 0) settle(4);
            end else begin
                tick();
            end
        end
    endtask

    task automatic test_reset();
        bit seen;
        settle(2);
        vectors++;
        if (is_spinning !== 1'b0 || result_valid !== 1'b0 || timeout !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got spin=%b rv=%b to=%b expected 0 0 0", is_spinning, result_valid, timeout);
        end
        vectors++;
        if (reel_sym !== 12'h000 || win_class !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_data: got sym=%h wc=%0d expected 000 0", reel_sym, win_class);
        end
        rst_n = 1'b1;
        start_spin();
        repeat (3) tick();
        vectors++;
        if (is_spinning !== 1'b1 || reel_sym !== pack_syms()) begin
            miscompares++;
            $display("[TB] FAIL pre_abort_spin: got spin=%b sym=%h expected 1 %h", is_spinning, reel_sym, pack_syms());
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (is_spinning !== 1'b0 || reel_sym !== 12'h000 || result_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL async_abort: got spin=%b sym=%h rv=%b expected 0 000 0", is_spinning, reel_sym, result_valid);
        end
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (result_valid === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL abort_no_result: got result pulse=%b expected 0", seen);
        end
        rst_n = 1'b1;
        start_spin();
        vectors++;
        if (is_spinning !== 1'b1 || reel_sym !== pack_syms()) begin
            miscompares++;
            $display("[TB] FAIL resume_spin: got spin=%b sym=%h expected 1 %h", is_spinning, reel_sym, pack_syms());
        end
        stop_in = 4'b1111;
        for (int i = 0; i < 4; i++) m_stopped[i] = 1'b1;
        begin
            bit f; logic [11:0] s; logic [1:0] w; logic t; int wd;
            wait_result(f, s, w, t, wd);
            vectors++;
            if (f !== 1'b1 || s !== pack_syms()) begin
                miscompares++;
                $display("[TB] FAIL resume_result: got found=%b sym=%h expected 1 %h", f, s, pack_syms());
            end
        end
        stop_in = 4'b0000;
        settle(4);
    endtask

    task automatic test_wrap_priority();
        bit f; logic [11:0] s; logic [1:0] w; logic t; int wd;
        start_spin();
        for (int k = 0; k < 6 && exp_sym[0] != 5; k++) tick();
        vectors++;
        if (reel_sym[2:0] !== 3'd5) begin
            miscompares++;
            $display("[TB] FAIL wrap_pre: got reel0=%0d expected 5", reel_sym[2:0]);
        end
        tick();
        vectors++;
        if (reel_sym[2:0] !== 3'd0) begin
            miscompares++;
            $display("[TB] FAIL wrap_5_to_0: got reel0=%0d expected 0", reel_sym[2:0]);
        end
        stop_in[1] = 1'b1;
        settle(2);
        m_stopped[1] = 1'b1;
        tick();
        vectors++;
        if (reel_sym !== pack_syms()) begin
            miscompares++;
            $display("[TB] FAIL stop_tick_priority: got sym=%h expected %h", reel_sym, pack_syms());
        end
        tick();
        vectors++;
        if (reel_sym !== pack_syms()) begin
            miscompares++;
            $display("[TB] FAIL stopped_holds: got sym=%h expected %h", reel_sym, pack_syms());
        end
        stop_in = 4'b1111;
        for (int i = 0; i < 4; i++) m_stopped[i] = 1'b1;
        wait_result(f, s, w, t, wd);
        vectors++;
        if (f !== 1'b1 || wd != 1) begin
            miscompares++;
            $display("[TB] FAIL wrap_result: got found=%b width=%0d expected 1 1", f, wd);
        end
        stop_in = 4'b0000;
        settle(4);
    endtask

    task automatic test_staggered();
        bit f; logic [11:0] s; logic [1:0] w; logic t; int wd;
        start_spin();
        repeat (10) tick();
        for (int r = 0; r < 3; r++) begin
            stop_in[r] = 1'b1;
            m_stopped[r] = 1'b1;
            settle(4);
            repeat (4) tick();
            vectors++;
            if (reel_sym !== pack_syms()) begin
                miscompares++;
                $display("[TB] FAIL stagger_stage%0d: got sym=%h expected %h", r, reel_sym, pack_syms());
            end
        end
        stop_in = 4'b1111;
        m_stopped[3] = 1'b1;
        wait_result(f, s, w, t, wd);
        vectors++;
        if (f !== 1'b1 || wd != 1) begin
            miscompares++;
            $display("[TB] FAIL stagger_pulse: got found=%b width=%0d expected 1 1", f, wd);
        end
        vectors++;
        if (s !== pack_syms() || w !== 2'(expected_class())) begin
            miscompares++;
            $display("[TB] FAIL stagger_outcome: got sym=%h wc=%0d expected %h %0d", s, w, pack_syms(), expected_class());
        end
        vectors++;
        if (is_spinning !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stagger_idle: got spin=%b expected 0", is_spinning);
        end
        stop_in = 4'b0000;
        settle(4);
    endtask

    task automatic test_watchdog();
        bit f;
        start_spin();
        repeat (100) tick();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (reel_sym !== pack_syms() || is_spinning !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL start_in_spin: got sym=%h spin=%b expected %h 1", reel_sym, is_spinning, pack_syms());
        end
        repeat (154) tick();
        vectors++;
        if (timeout !== 1'b0 || is_spinning !== 1'b1 || result_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL wd_254: got to=%b spin=%b rv=%b expected 0 1 0", timeout, is_spinning, result_valid);
        end
        spin_tick = 1'b1;
        @(negedge clk);
        spin_tick = 1'b0;
        f = 1'b0;
        for (int k = 0; k < 10 && !f; k++) begin
            @(negedge clk);
            if (result_valid === 1'b1) f = 1'b1;
        end
        vectors++;
        if (f !== 1'b1 || timeout !== 1'b1 || is_spinning !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL wd_fire: got found=%b to=%b spin=%b expected 1 1 0", f, timeout, is_spinning);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (result_valid !== 1'b0 || is_spinning !== 1'b0 || timeout !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL start_in_eval: got rv=%b spin=%b to=%b expected 0 0 1", result_valid, is_spinning, timeout);
        end
        settle(2);
        vectors++;
        if (is_spinning !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL eval_start_ignored: got spin=%b expected 0", is_spinning);
        end
    endtask

    task automatic test_jackpot();
        bit f; logic [11:0] s; logic [1:0] w; logic t; int wd;
        start_spin();
        vectors++;
        if (timeout !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL timeout_cleared: got to=%b expected 0", timeout);
        end
        spin_to(2, 2, 2, 2);
        wait_result(f, s, w, t, wd);
        vectors++;
        if (f !== 1'b1 || s !== 12'h492 || w !== 2'd3 || t !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL jackpot: got found=%b sym=%h wc=%0d to=%b expected 1 492 3 0", f, s, w, t);
        end
        stop_in = 4'b0000;
        settle(4);
    endtask

    task automatic test_classes();
        bit f; logic [11:0] s; logic [1:0] w; logic t; int wd;
        start_spin();
        spin_to(1, 1, 1, 4);
        wait_result(f, s, w, t, wd);
        vectors++;
        if (f !== 1'b1 || s !== 12'h849 || w !== 2'd2) begin
            miscompares++;
            $display("[TB] FAIL class_triple: got found=%b sym=%h wc=%0d expected 1 849 2", f, s, w);
        end
        stop_in = 4'b0000;
        settle(4);
        start_spin();
        spin_to(0, 0, 3, 3);
        wait_result(f, s, w, t, wd);
        vectors++;
        if (f !== 1'b1 || s !== 12'h6C0 || w !== 2'd1) begin
            miscompares++;
            $display("[TB] FAIL class_pair: got found=%b sym=%h wc=%0d expected 1 6c0 1", f, s, w);
        end
        stop_in = 4'b0000;
        settle(4);
        start_spin();
        spin_to(0, 1, 2, 3);
        wait_result(f, s, w, t, wd);
        vectors++;
        if (f !== 1'b1 || s !== 12'h688 || w !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL class_none: got found=%b sym=%h wc=%0d expected 1 688 0", f, s, w);
        end
        vectors++;
        if (win_class !== 2'd0 || s !== reel_sym) begin
            miscompares++;
            $display("[TB] FAIL idle_hold: got wc=%0d sym=%h expected 0 688", win_class, reel_sym);
        end
        stop_in = 4'b0000;
        settle(4);
    endtask

    initial begin
        $display("[TB] reel_bank bench starting");
        test_reset();
        test_wrap_priority();
        test_staggered();
        test_watchdog();
        test_jackpot();
        test_classes();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reel_bank.md
REEL_BANK -- requirements
Module: reel_bank

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: start  input  1  one-cycle spin request pulse.
REQ-004 SHALL have port: spin_tick  input  1  one-cycle reel-advance enable.
REQ-005 SHALL have port: stop_in  input  4  per-reel stop levels from the stop-sequence generator; bit i = reel i; asynchronous to clk.
REQ-006 SHALL have port: is_spinning  output  1  high while any reel is spinning; drives the stop-sequence generator.
REQ-007 SHALL have port: reel_sym  output  12  four 3-bit symbols, reel i at [3i+2:3i].
REQ-008 SHALL have port: result_valid  output  1  one-cycle pulse when the spin outcome is final.
REQ-009 SHALL have port: win_class  output  2  outcome class; held until the next start.
REQ-010 SHALL have port: timeout  output  1  set when the watchdog forced the stop; held until the next start.

Function
REQ-011 SHALL implement FSM IDLE -> SPIN -> EVAL -> IDLE.
REQ-012 SHALL stay in IDLE while start=0; in IDLE, start=1 SHALL move to SPIN next cycle.
REQ-013 SHALL, on the IDLE->SPIN transition, load reel i with (lfsr[2i+2:2i] mod 6), clear stopped[3:0], timeout and watchdog.
REQ-014 SHALL run an 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5) advancing every clk cycle in all states.
REQ-015 SHALL pass stop_in through a 2-flop synchronizer per bit before use; stop latency is 2 clk cycles plus edge detect.
REQ-016 SHALL, in SPIN, set stopped[i] on the first cycle synchronized stop_in[i] is high; stopped[i] stays set until the next start.
REQ-017 SHALL, in SPIN, advance each reel with stopped[i]=0 by one on spin_tick, wrapping 5 -> 0; symbols 6 and 7 never appear.
REQ-018 SHALL give priority to stop: a reel whose stop is detected in the same cycle as spin_tick does not advance.
REQ-019 SHALL ignore stop_in in IDLE and EVAL; stop levels already high at start SHALL stop that reel on the first SPIN cycle after synchronization.
REQ-020 SHALL count spin_tick in SPIN; on the 255th tick with any stopped[i]=0, set all stopped, set timeout.
REQ-021 SHALL move SPIN -> EVAL on the cycle after stopped becomes 4'b1111.
REQ-022 SHALL, in EVAL, compute m = max count of identical symbols over the four reels; win_class = 3 if m=4, 2 if m=3, 1 if m=2, 0 if m=1.
REQ-023 SHALL assert result_valid for exactly the single EVAL cycle, with win_class valid in that cycle, then return to IDLE.
REQ-024 SHALL ignore start in SPIN and EVAL (no restart, no reload).
REQ-025 SHALL drive is_spinning high exactly while state=SPIN.
REQ-026 SHALL hold reel_sym stable in IDLE and EVAL.

Reset
REQ-027 SHALL, on rst_n low at any time, asynchronously force: state IDLE, reels 0, stopped 0, synchronizers 0, watchdog 0, LFSR 8'hA5, is_spinning 0, result_valid 0, win_class 0, timeout 0.
REQ-028 SHALL abort a spin in progress on reset with no result_valid pulse.
REQ-029 SHALL resume normal operation on the first clk edge after rst_n rises.

Structure
REQ-030 SHALL place in shared package slot_pkg: SYM_W=3, SYM_COUNT=6, NUM_REELS=4, WATCHDOG_TICKS=255, LFSR_SEED=8'hA5, the state encoding and win_class encoding (NONE=0, PAIR=1, TRIPLE=2, JACKPOT=3).
REQ-031 SHALL instantiate sub-module reel_counter once per reel (load, advance, hold, mod-6 wrap); synchronizers and FSM stay in reel_bank.

Verification
REQ-032 Reset: rst_n low mid-SPIN -> same cycle is_spinning=0, reel_sym=0, no result_valid; rst_n high, start -> normal spin.
REQ-033 Staggered stop: start, 10 spin_ticks, stop_in 0001,0011,0111,1111 at 4-tick spacing -> reel 0 frozen first, later reels advance 4 more ticks each; one result_valid pulse; win_class matches REQ-022.
REQ-034 Jackpot: force reels to symbol 2 (LFSR seed plus tick alignment), stop all -> reel_sym=12'h492, win_class=3.
REQ-035 Wrap and priority: reel at 5 plus spin_tick -> 0; stop and spin_tick same cycle -> reel does not advance.
REQ-036 Watchdog: start, stop_in held 0 for 255 spin_ticks -> timeout=1, result_valid pulse, is_spinning falls; start ignored during SPIN/EVAL.
REQ-037 Classes: symbols {1,1,1,4} -> 2; {0,0,3,3} -> 1; {0,1,2,3} -> 0.
